iob_dbg_tx: RTL

Transmit end of the IOB-to-JBI debug port. Captures two 48-bit internal debug source buses (hi and lo) and drives the iob_jbi_dbg_{hi,lo}_{data,vld} signals consumed by the JBI debug block. Provides a trigger/arm state machine, change-only filtering, a per-channel minimum inter-sample gap and a capture sample limit. The bus has no backpressure, so the block's rate control is the only throttle.

---
 rtl/iob_dbg_tx_if.sv | 28 ++
 rtl/iob_dbg_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/iob_dbg_tx_if.sv
// Debug source / JBI debug bus bundle for the IOB debug transmitter.
//   src_{hi,lo}_data/vld           : internal debug source buses (into iob_dbg_tx)
//   iob_jbi_dbg_{hi,lo}_data/vld   : registered debug samples toward JBI
// Modports:
//   slave  : the transmitter (consumes sources, drives the JBI side)
//   master : the environment (drives sources, observes the JBI side)
interface iob_dbg_tx_if;
    logic [47:0] src_hi_data;
    logic        src_hi_vld;
    logic [47:0] src_lo_data;
    logic        src_lo_vld;
    logic [47:0] iob_jbi_dbg_hi_data;
    logic        iob_jbi_dbg_hi_vld;
    logic [47:0] iob_jbi_dbg_lo_data;
    logic        iob_jbi_dbg_lo_vld;

    modport slave (
        input  src_hi_data, src_hi_vld, src_lo_data, src_lo_vld,
        output iob_jbi_dbg_hi_data, iob_jbi_dbg_hi_vld,
               iob_jbi_dbg_lo_data, iob_jbi_dbg_lo_vld
    );

    modport master (
        output src_hi_data, src_hi_vld, src_lo_data, src_lo_vld,
        input  iob_jbi_dbg_hi_data, iob_jbi_dbg_hi_vld,
               iob_jbi_dbg_lo_data, iob_jbi_dbg_lo_vld
    );
endinterface

// File: rtl/iob_dbg_tx.sv
// Transmit end of the IOB-to-JBI debug port.
// Captures the hi/lo debug source buses and forwards them to JBI under a
// trigger/arm FSM, with change-only filtering, a per-channel minimum gap
// between valids and a capture sample limit. The JBI side has no
// backpressure, so the gap/limit logic here is the only rate control.
//
// Ports:
//   clk, rst_l           : core clock, asynchronous active-low reset
//   csr_dbg_*            : configuration (enable, arm pulse, trigger mask/match,
//                          change-only, min gap, sample limit; 0 = unlimited)
//   dbg (slave)          : source buses in, iob_jbi_dbg_* out (latency 1)
//   dbg_tx_state         : 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   dbg_tx_ovf           : sticky, a qualified sample was dropped by the gap limit
//
// Optional build macro: IOB_DBG_TX_SEQ_EN
//   When defined, each channel stamps a 4-bit wrapping sequence number into
//   bits [47:44] of every sent sample. Undefined: data is passed unmodified.
//
// state    | meaning
// IDLE     | disabled or never armed, nothing sent
// ARMED    | waiting for hi trigger match
// CAPTURE  | forwarding qualified samples
// DONE     | sample limit reached, waiting for re-arm
module iob_dbg_tx #(
    parameter int GAP_WIDTH = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 csr_dbg_en,
    input  logic                 csr_dbg_arm,
    input  logic [47:0]          csr_dbg_trig_mask,
    input  logic [47:0]          csr_dbg_trig_match,
    input  logic                 csr_dbg_chg_only,
    input  logic [GAP_WIDTH-1:0] csr_dbg_min_gap,
    input  logic [CNT_WIDTH-1:0] csr_dbg_sample_cnt,
    iob_dbg_tx_if.slave          dbg,
    output logic [1:0]           dbg_tx_state,
    output logic                 dbg_tx_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               state;
    logic [GAP_WIDTH-1:0] gap_hi, gap_lo;
    logic [CNT_WIDTH-1:0] send_cnt;
    logic [47:0]          last_hi, last_lo;
    logic                 last_valid_hi, last_valid_lo;
`ifdef IOB_DBG_TX_SEQ_EN
    logic [3:0]           seq_hi, seq_lo;
`endif

    logic                 arm_go, trig, eligible;
    logic                 qual_hi, qual_lo, send_hi, send_lo, drop_any, any_send;
    logic [CNT_WIDTH-1:0] send_cnt_nxt;
    logic                 limit_hit;
    logic [47:0]          payload_hi, payload_lo;

    always_comb begin
        arm_go   = csr_dbg_en && csr_dbg_arm;
        trig     = (state == ST_ARMED) && dbg.src_hi_vld &&
                   (((dbg.src_hi_data ^ csr_dbg_trig_match) & csr_dbg_trig_mask) == 48'd0);
        // Arm wins over a same-cycle trigger, so nothing is sent on an arm cycle.
        eligible = csr_dbg_en && !csr_dbg_arm && ((state == ST_CAPTURE) || trig);
        qual_hi  = eligible && dbg.src_hi_vld &&
                   (!csr_dbg_chg_only || !last_valid_hi || (dbg.src_hi_data != last_hi));
        qual_lo  = eligible && dbg.src_lo_vld &&
                   (!csr_dbg_chg_only || !last_valid_lo || (dbg.src_lo_data != last_lo));
        send_hi  = qual_hi && (gap_hi == '0);
        send_lo  = qual_lo && (gap_lo == '0);
        drop_any = (qual_hi && (gap_hi != '0)) || (qual_lo && (gap_lo != '0));
        any_send = send_hi || send_lo;
        send_cnt_nxt = (send_cnt == '1) ? send_cnt : send_cnt + 1'b1;
        limit_hit = any_send && (csr_dbg_sample_cnt != '0) &&
                    (send_cnt_nxt == csr_dbg_sample_cnt);
`ifdef IOB_DBG_TX_SEQ_EN
        payload_hi = {seq_hi, dbg.src_hi_data[43:0]};
        payload_lo = {seq_lo, dbg.src_lo_data[43:0]};
`else
        payload_hi = dbg.src_hi_data;
        payload_lo = dbg.src_lo_data;
`endif
    end

    assign dbg_tx_state = state;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state                   <= ST_IDLE;
            gap_hi                  <= '0;
            gap_lo                  <= '0;
            send_cnt                <= '0;
            last_hi                 <= '0;
            last_lo                 <= '0;
            last_valid_hi           <= 1'b0;
            last_valid_lo           <= 1'b0;
            dbg_tx_ovf              <= 1'b0;
            dbg.iob_jbi_dbg_hi_vld  <= 1'b0;
            dbg.iob_jbi_dbg_lo_vld  <= 1'b0;
            dbg.iob_jbi_dbg_hi_data <= '0;
            dbg.iob_jbi_dbg_lo_data <= '0;
`ifdef IOB_DBG_TX_SEQ_EN
            seq_hi                  <= '0;
            seq_lo                  <= '0;
`endif
        end else begin
            dbg.iob_jbi_dbg_hi_vld <= 1'b0;
            dbg.iob_jbi_dbg_lo_vld <= 1'b0;
            if (gap_hi != '0) gap_hi <= gap_hi - 1'b1;
            if (gap_lo != '0) gap_lo <= gap_lo - 1'b1;

            if (!csr_dbg_en) begin
                state <= ST_IDLE;
            end else if (arm_go) begin
                state         <= ST_ARMED;
                send_cnt      <= '0;
                gap_hi        <= '0;
                gap_lo        <= '0;
                last_valid_hi <= 1'b0;
                last_valid_lo <= 1'b0;
                dbg_tx_ovf    <= 1'b0;
`ifdef IOB_DBG_TX_SEQ_EN
                seq_hi        <= '0;
                seq_lo        <= '0;
`endif
            end else begin
                if (send_hi) begin
                    dbg.iob_jbi_dbg_hi_vld  <= 1'b1;
                    dbg.iob_jbi_dbg_hi_data <= payload_hi;
                    gap_hi                  <= csr_dbg_min_gap;
                    last_hi                 <= dbg.src_hi_data;
                    last_valid_hi           <= 1'b1;
`ifdef IOB_DBG_TX_SEQ_EN
                    seq_hi                  <= seq_hi + 4'd1;
`endif
                end
                if (send_lo) begin
                    dbg.iob_jbi_dbg_lo_vld  <= 1'b1;
                    dbg.iob_jbi_dbg_lo_data <= payload_lo;
                    gap_lo                  <= csr_dbg_min_gap;
                    last_lo                 <= dbg.src_lo_data;
                    last_valid_lo           <= 1'b1;
`ifdef IOB_DBG_TX_SEQ_EN
                    seq_lo                  <= seq_lo + 4'd1;
`endif
                end
                if (drop_any) dbg_tx_ovf <= 1'b1;
                if (any_send) send_cnt   <= send_cnt_nxt;

                if (trig) state <= ST_CAPTURE;
                // A send on the trigger cycle already counts toward the limit.
                if (((state == ST_CAPTURE) || trig) && limit_hit) state <= ST_DONE;
            end
        end
    end

endmodule
